// File: rtl/nand_seq_pkg.sv
// Shared definitions for the NAND-chain sequencer: FSM encoding and the
// stage-index width helper.
package nand_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bits needed to hold a stage index 0..n (never narrower than 1).
  function automatic int stage_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/nand2_unit.sv
// Shared W-bit 2-input NAND. Purely combinational. The sequencer
// instantiates it exactly once and reuses it for every stage of the chain.
module nand2_unit #(
  parameter int W = 1
) (
  input  logic [W-1:0] x0,
  input  logic [W-1:0] x1,
  output logic [W-1:0] y
);

  assign y = ~(x0 & x1);

endmodule

// File: rtl/nand_chain_seq.sv
// Time-multiplexed NAND chain: g = ~(...~(~(op0&op1)&op2)...&opN).
// One stage is evaluated per clock on a single nand2_unit.
// Optional build macro NAND_SEQ_STAGE_OUT_EN adds stage_out, which holds the
// output of every intermediate stage.
module nand_chain_seq
  import nand_seq_pkg::*;
#(
  parameter  int W      = 1,
  parameter  int STAGES = 3,
  localparam int SW     = stage_w(STAGES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [(STAGES+1)*W-1:0] op_in,
  output logic                  busy,
  output logic                  done,
  output logic [W-1:0]          result,
  output logic [SW-1:0]         stage
`ifdef NAND_SEQ_STAGE_OUT_EN
  ,
  output logic [STAGES*W-1:0]   stage_out
`endif
);

  state_t                 state;
  logic [STAGES:0][W-1:0] op_reg;
  logic [W-1:0]           acc;
  logic [W-1:0]           nand_y;

  // The operand mux sits here; the NAND gate is shared by every stage.
  nand2_unit #(.W(W)) u_nand (
    .x0 (acc),
    .x1 (op_reg[stage]),
    .y  (nand_y)
  );

  // FSM plus datapath. busy and done are registered from the state, so they
  // trail the state by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      stage  <= '0;
      acc    <= '0;
      op_reg <= '0;
`ifdef NAND_SEQ_STAGE_OUT_EN
      stage_out <= '0;
`endif
    end else begin
      busy <= (state != S_IDLE);
      done <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            op_reg <= op_in;
            acc    <= op_in[W-1:0];
            stage  <= SW'(1);
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          acc <= nand_y;
`ifdef NAND_SEQ_STAGE_OUT_EN
          stage_out[(int'(stage) - 1) * W +: W] <= nand_y;
`endif
          // The last stage holds its index instead of wrapping; DONE clears it.
          if (stage == SW'(STAGES)) begin
            result <= nand_y;
            state  <= S_DONE;
          end else begin
            stage <= stage + 1'b1;
          end
        end
        S_DONE: begin
          stage <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_chain_seq.sv
// Directed bench for nand_chain_seq: W=1/STAGES=3 table vectors plus
// multi-cycle corner sequences, and a W=4 instance for the wide case.
module tb_nand_chain_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start4;
  logic [3:0] op1;
  logic [15:0] op4;
  logic       busy1, done1, res1;
  logic [1:0] stage1;
  logic       busy4, done4;
  logic [3:0] res4;
  logic [1:0] stage4;
`ifdef NAND_SEQ_STAGE_OUT_EN
  logic [2:0]  so1;
  logic [11:0] so4;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nand_chain_seq #(.W(1), .STAGES(3)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op_in(op1),
    .busy(busy1), .done(done1), .result(res1), .stage(stage1)
`ifdef NAND_SEQ_STAGE_OUT_EN
    , .stage_out(so1)
`endif
  );

  nand_chain_seq #(.W(4), .STAGES(3)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .op_in(op4),
    .busy(busy4), .done(done4), .result(res4), .stage(stage4)
`ifdef NAND_SEQ_STAGE_OUT_EN
    , .stage_out(so4)
`endif
  );

  typedef struct {
    logic [3:0] ops;  // {d,c,b,a}
    logic       res;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one request on dut1 and check the full timeline cycles T..T+5.
  task automatic run_vec(input logic [3:0] ops, input logic res, input int id);
    logic [1:0] est;
    op1    = ops;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    op1    = 4'($urandom);
    for (int k = 0; k < 6; k++) begin
      est = (k < 3) ? 2'(k + 1) : (k == 3) ? 2'd3 : 2'd0;
      chk($sformatf("v%0d busy c%0d", id, k), busy1, (k >= 1 && k <= 4));
      chk($sformatf("v%0d done c%0d", id, k), done1, (k == 4));
      chk($sformatf("v%0d stage c%0d", id, k), stage1, est);
      if (k == 4) chk($sformatf("v%0d result", id), res1, res);
      step();
    end
  endtask

  initial begin
    bit seen;
    vecs[0] = '{4'b1111, 1'b0};
    vecs[1] = '{4'b1100, 1'b1};
    vecs[2] = '{4'b1010, 1'b0};
    vecs[3] = '{4'b0011, 1'b1};
    vecs[4] = '{4'b1101, 1'b1};
    vecs[5] = '{4'b0111, 1'b1};
    vecs[6] = '{4'b0000, 1'b1};

    rst = 1'b1; start1 = 1'b0; start4 = 1'b0; op1 = '0; op4 = '0;
    step();
    step();
    chk("rst busy", busy1, 0);
    chk("rst done", done1, 0);
    chk("rst result", res1, 0);
    chk("rst stage", stage1, 0);
    chk("rst result4", res4, 0);
`ifdef NAND_SEQ_STAGE_OUT_EN
    chk("rst stage_out", so1, 0);
`endif
    rst = 1'b0;
    step();

    foreach (vecs[i]) run_vec(vecs[i].ops, vecs[i].res, i);

    // start held for 10 cycles, operands changed after T: only T and T+5 taken.
    op1 = 4'b1111;
    start1 = 1'b1;
    step();
    for (int k = 0; k < 12; k++) begin
      if (k == 0) op1 = 4'b1100;
      chk($sformatf("hold done c%0d", k), done1, (k == 4 || k == 9));
      if (k == 4) begin
        chk("hold result1", res1, 0);
        chk("hold stage c4", stage1, 0);
      end
      if (k == 5) chk("hold reaccept stage", stage1, 1);
      if (k == 9) begin
        chk("hold result2", res1, 1);
        start1 = 1'b0;
      end
      step();
    end
    step();

    // Reset during RUN: abort with no done pulse and a cleared result.
    chk("pre-abort result", res1, 1);
    op1 = 4'b1100;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort busy", busy1, 0);
    chk("abort result", res1, 0);
    chk("abort stage", stage1, 0);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (done1 || busy1) seen = 1'b1;
      step();
    end
    chk("abort no done", seen, 0);
    run_vec(4'b1100, 1'b1, 99);

    // W=4: a=F b=A c=C d=3 -> 5, B, C.
    op4 = 16'h3CAF;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    op4 = '0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (done4) seen = 1'b1;
      else step();
    end
    chk("w4 done seen", seen, 1);
    chk("w4 result", res4, 4'hC);
`ifdef NAND_SEQ_STAGE_OUT_EN
    chk("w4 stage_out", so4, 12'hCB5);
    step();
    chk("w4 stage_out held", so4, 12'hCB5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
